// File: rtl/bmc_frame_packer.sv
// bmc_frame_packer
//   Captures each completed word and timestamp from the BMC decoder,
//   acknowledges the decoder with a one-cycle clear pulse, buffers the
//   captures in a small FIFO and sends each one to the host MCU as an
//   8-byte 8N1 UART frame:
//   A5, {SENSOR_ID,5'b0,d[16]}, d[15:8], d[7:0], ts[23:16], ts[15:8],
//   ts[7:0], xor(B1..B6).
//
// Ports
//   clk_96MHz       system clock
//   reset           asynchronous, active-low reset
//   decoded_data    decoded word from the decoder
//   data_availible  decoder level flag, high until the decoder is cleared
//   ts_last_data    timestamp latched by the decoder with the word
//   decoder_ack     one-cycle pulse to the decoder's clear input
//   tx              UART line, idle high
//   fifo_level      current number of buffered captures
//   overflow_count  captures dropped on a full FIFO (saturating)
//   busy            high while a frame is being transmitted
module bmc_frame_packer #(
    parameter int unsigned BIT_CONSIDERED = 17,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned BAUD_DIV       = 96,
    parameter logic [1:0]  SENSOR_ID      = 2'd0
) (
    input  logic                          clk_96MHz,
    input  logic                          reset,
    input  logic [BIT_CONSIDERED-1:0]     decoded_data,
    input  logic                          data_availible,
    input  logic [23:0]                   ts_last_data,
    output logic                          decoder_ack,
    output logic                          tx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    overflow_count,
    output logic                          busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam int unsigned EW = 24 + BIT_CONSIDERED;
    localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // capture / FIFO state
    logic            da_q;
    logic            ack_q;
    logic [LW-1:0]   level_q;
    logic [7:0]      ovf_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    // transmitter state
    state_t          state_q;
    logic            tx_q;
    logic            busy_q;
    logic [CW-1:0]   baud_q;
    logic [2:0]      bit_idx_q;
    logic [2:0]      byte_idx_q;
    logic [63:0]     frame_q;

    logic            cap;
    logic            full;
    logic            not_empty;
    logic            pop;
    logic            push;
    logic            drop;
    logic [EW-1:0]   head;
    logic [16:0]     data17;
    logic [23:0]     ts;
    logic [7:0]      b1, b2, b3, b4, b5, b6;
    logic [63:0]     frame_d;
    logic [7:0]      cur_byte;
    logic [2:0]      bit_nxt;

    // Only the rising edge of the decoder flag captures, so a decoder that is
    // slow to clear never produces duplicates.
    assign cap       = data_availible & ~da_q;
    assign full      = (level_q == FULL_LVL);
    assign not_empty = (level_q != '0);
    assign pop       = (state_q == S_LOAD);
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign push      = cap & (~full | pop);
    assign drop      = cap & full & ~pop;

    always_ff @(posedge clk_96MHz or negedge reset) begin
        if (!reset) begin
            da_q     <= 1'b0;
            ack_q    <= 1'b0;
            level_q  <= '0;
            ovf_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            da_q  <= data_availible;
            ack_q <= cap;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (drop && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'd1;
        end
    end

    // Storage carries no reset; pointer reset alone empties the FIFO.
    always_ff @(posedge clk_96MHz) begin
        if (push) mem_q[wr_ptr_q] <= {ts_last_data, decoded_data};
    end

    // Frame assembly from the FIFO head; B0 sits in the low byte so the
    // byte index selects directly.
    always_comb begin
        head   = mem_q[rd_ptr_q];
        data17 = '0;
        data17[BIT_CONSIDERED-1:0] = head[BIT_CONSIDERED-1:0];
        ts     = head[EW-1:BIT_CONSIDERED];
        b1     = {SENSOR_ID, 5'b0, data17[16]};
        b2     = data17[15:8];
        b3     = data17[7:0];
        b4     = ts[23:16];
        b5     = ts[15:8];
        b6     = ts[7:0];
        frame_d = {b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6, b6, b5, b4, b3, b2, b1, 8'hA5};
        cur_byte = frame_q[{byte_idx_q, 3'b000} +: 8];
        bit_nxt  = bit_idx_q + 3'd1;
    end

    always_ff @(posedge clk_96MHz or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            frame_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (not_empty) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    frame_q    <= frame_d;
                    byte_idx_q <= '0;
                    baud_q     <= '0;
                    tx_q       <= 1'b0;
                    state_q    <= S_START;
                end
                S_START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= cur_byte[0];
                        state_q   <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_nxt;
                            tx_q      <= cur_byte[bit_nxt];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (byte_idx_q != 3'd7) begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                            tx_q       <= 1'b0;
                            state_q    <= S_START;
                        end else if (not_empty) begin
                            // Back-to-back: skip IDLE so the only gap is LOAD.
                            state_q <= S_LOAD;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign decoder_ack    = ack_q;
    assign tx             = tx_q;
    assign fifo_level     = level_q;
    assign overflow_count = ovf_q;
    assign busy           = busy_q;

endmodule
